// File: rtl/tmr_resync_scheduler.sv
// Purpose : supervises a triple-modular-redundant core set; qualifies persistent voter
//           minority flags, pulses core resets to resync, isolates repeat offenders.
// Latency : all outputs registered; a decision taken on edge N is visible after edge N.
// Backpressure: none -- mismatch/resync inputs are sampled every cycle, ignored outside RUN/QUALIFY.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mismatch_a/b/c               voter minority flag per core
//   resync_req                   software resync request pulse
//   rst_n_core_a/b/c             active-low core resets
//   isolated[2:0] {c,b,a}        cores permanently held in reset
//   degraded / fatal / busy      any core isolated / terminal disagreement / not in RUN
//   state_o                      FSM state (INIT=0 RUN=1 QUALIFY=2 HOLD=3 SETTLE=4 FATAL=5)
//   fault_cnt_a/b/c              qualified faults per core (saturating)
//   transient_cnt, resync_count  unqualified mismatch episodes / completed resyncs (saturating)
module tmr_resync_scheduler #(
  parameter int PERSIST_CYCLES = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mismatch_a,
  input  logic       mismatch_b,
  input  logic       mismatch_c,
  input  logic       resync_req,
  output logic       rst_n_core_a,
  output logic       rst_n_core_b,
  output logic       rst_n_core_c,
  output logic [2:0] isolated,
  output logic       degraded,
  output logic       fatal,
  output logic       busy,
  output logic [2:0] state_o,
  output logic [3:0] fault_cnt_a,
  output logic [3:0] fault_cnt_b,
  output logic [3:0] fault_cnt_c,
  output logic [7:0] transient_cnt,
  output logic [7:0] resync_count
);

  localparam int MAXP_A = (PERSIST_CYCLES > HOLD_CYCLES) ? PERSIST_CYCLES : HOLD_CYCLES;
  localparam int MAXP_B = (SETTLE_CYCLES > MAX_RETRIES) ? SETTLE_CYCLES : MAX_RETRIES;
  localparam int MAXP   = (MAXP_A > MAXP_B) ? MAXP_A : MAXP_B;
  localparam int CW     = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_RUN     = 3'd1,
    S_QUALIFY = 3'd2,
    S_HOLD    = 3'd3,
    S_SETTLE  = 3'd4,
    S_FATAL   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   persist_q, persist_d;
  logic [1:0]      suspect_q, suspect_d;
  logic [2:0]      iso_q, iso_d;
  logic [2:0][3:0] fcnt_q, fcnt_d;
  logic [7:0]      trans_q, trans_d;
  logic [7:0]      resync_q, resync_d;
  logic [2:0]      rstn_q, rstn_d;
  logic            busy_q, busy_d;
  logic            fatal_q, fatal_d;
  logic            degraded_q, degraded_d;

  logic [2:0]    m;
  logic [1:0]    pop;
  logic [1:0]    m_idx;
  logic [2:0]    sus_mask;
  logic [CW-1:0] persist_inc;
  logic [3:0]    fc_new;
  logic          hold_with_suspect;
  logic          timed_state;

  // Isolated cores no longer participate in voting decisions.
  assign m           = {mismatch_c, mismatch_b, mismatch_a} & ~iso_q;
  assign pop         = {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  assign m_idx       = m[0] ? 2'd0 : (m[1] ? 2'd1 : 2'd2);
  assign sus_mask    = 3'b001 << suspect_q;
  assign persist_inc = persist_q + 1'b1;
  assign fc_new      = (fcnt_q[suspect_q] == 4'hF) ? 4'hF : fcnt_q[suspect_q] + 4'd1;

  always_comb begin
    state_d           = state_q;
    persist_d         = persist_q;
    suspect_d         = suspect_q;
    iso_d             = iso_q;
    fcnt_d            = fcnt_q;
    trans_d           = trans_q;
    resync_d          = resync_q;
    hold_with_suspect = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (resync_req) begin
          state_d = S_HOLD;
        end else if (pop >= 2'd2) begin
          state_d = S_FATAL;
        end else if (pop == 2'd1 && (|iso_q)) begin
          // Only two voters remain: a lone disagreement cannot be attributed.
          state_d = S_FATAL;
        end else if (pop == 2'd1) begin
          state_d   = S_QUALIFY;
          suspect_d = m_idx;
          persist_d = CW'(1);
        end
      end
      S_QUALIFY: begin
        if ((m & ~sus_mask) != 3'b000) begin
          state_d = S_FATAL;
        end else if ((m & sus_mask) != 3'b000) begin
          persist_d = persist_inc;
          if (persist_inc >= CW'(PERSIST_CYCLES)) begin
            state_d           = S_HOLD;
            hold_with_suspect = 1'b1;
          end
        end else begin
          state_d = S_RUN;
          trans_d = (trans_q == 8'hFF) ? trans_q : trans_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d  = S_SETTLE;
          resync_d = (resync_q == 8'hFF) ? resync_q : resync_q + 8'd1;
        end
      end
      S_FATAL: state_d = S_FATAL;
      default: state_d = S_INIT;
    endcase

    // Fault accounting and isolation land on the same edge as HOLD entry,
    // so the core reset mask below already reflects the new isolation.
    if (hold_with_suspect) begin
      fcnt_d[suspect_q] = fc_new;
      if ({28'd0, fc_new} >= 32'(MAX_RETRIES)) iso_d[suspect_q] = 1'b1;
    end
  end

  // Cycle counter only advances in the timed states and restarts on any state change.
  assign timed_state = (state_q == S_INIT) || (state_q == S_HOLD) || (state_q == S_SETTLE);
  assign cnt_d       = (state_d != state_q || !timed_state) ? '0 : cnt_q + 1'b1;

  // Registered outputs are derived from next-state so they move with the transition edge.
  always_comb begin
    if (state_d == S_INIT || state_d == S_HOLD || state_d == S_FATAL) rstn_d = 3'b000;
    else                                                               rstn_d = ~iso_d;
    busy_d     = (state_d != S_RUN);
    fatal_d    = (state_d == S_FATAL);
    degraded_d = |iso_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      persist_q  <= '0;
      suspect_q  <= 2'd0;
      iso_q      <= 3'b000;
      fcnt_q     <= '0;
      trans_q    <= 8'd0;
      resync_q   <= 8'd0;
      rstn_q     <= 3'b000;
      busy_q     <= 1'b1;
      fatal_q    <= 1'b0;
      degraded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      persist_q  <= persist_d;
      suspect_q  <= suspect_d;
      iso_q      <= iso_d;
      fcnt_q     <= fcnt_d;
      trans_q    <= trans_d;
      resync_q   <= resync_d;
      rstn_q     <= rstn_d;
      busy_q     <= busy_d;
      fatal_q    <= fatal_d;
      degraded_q <= degraded_d;
    end
  end

  assign state_o       = state_q;
  assign rst_n_core_a  = rstn_q[0];
  assign rst_n_core_b  = rstn_q[1];
  assign rst_n_core_c  = rstn_q[2];
  assign isolated      = iso_q;
  assign degraded      = degraded_q;
  assign fatal         = fatal_q;
  assign busy          = busy_q;
  assign fault_cnt_a   = fcnt_q[0];
  assign fault_cnt_b   = fcnt_q[1];
  assign fault_cnt_c   = fcnt_q[2];
  assign transient_cnt = trans_q;
  assign resync_count  = resync_q;

endmodule

// File: tb/tb_tmr_resync_scheduler.sv
// Bench for tmr_resync_scheduler: directed vector table, hand sequences for the
// multi-cycle corners, then a long randomized run against a countdown-timer model.
// Inputs change 1 time unit after the rising edge; outputs are compared there too.
module tb_tmr_resync_scheduler;

  localparam int PERSIST = 4;
  localparam int HOLD    = 16;
  localparam int SETTLE  = 8;
  localparam int MAXR    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mismatch_a = 1'b0, mismatch_b = 1'b0, mismatch_c = 1'b0;
  logic       resync_req = 1'b0;
  logic       rst_n_core_a, rst_n_core_b, rst_n_core_c;
  logic [2:0] isolated;
  logic       degraded, fatal, busy;
  logic [2:0] state_o;
  logic [3:0] fault_cnt_a, fault_cnt_b, fault_cnt_c;
  logic [7:0] transient_cnt, resync_count;

  tmr_resync_scheduler #(
    .PERSIST_CYCLES(PERSIST), .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst(rst),
    .mismatch_a(mismatch_a), .mismatch_b(mismatch_b), .mismatch_c(mismatch_c),
    .resync_req(resync_req),
    .rst_n_core_a(rst_n_core_a), .rst_n_core_b(rst_n_core_b), .rst_n_core_c(rst_n_core_c),
    .isolated(isolated), .degraded(degraded), .fatal(fatal), .busy(busy),
    .state_o(state_o),
    .fault_cnt_a(fault_cnt_a), .fault_cnt_b(fault_cnt_b), .fault_cnt_c(fault_cnt_c),
    .transient_cnt(transient_cnt), .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (phases with countdown timers) ----------------
  int       md_state = 0;  // 0 INIT 1 RUN 2 QUALIFY 3 HOLD 4 SETTLE 5 FATAL
  int       md_timer = HOLD;
  int       md_persist = 0;
  int       md_sus = 0;
  bit [2:0] md_iso = 3'b000;
  int       md_fc[3] = '{0, 0, 0};
  int       md_trans = 0;
  int       md_res = 0;

  task automatic md_enter_hold(input int s);
    md_state = 3;
    md_timer = HOLD;
    if (s >= 0) begin
      if (md_fc[s] < 15) md_fc[s] = md_fc[s] + 1;
      if (md_fc[s] >= MAXR) md_iso[s] = 1'b1;
    end
  endtask

  task automatic model_step(input bit r, input bit [2:0] mis, input bit req);
    bit [2:0] m;
    int       n;
    if (r) begin
      md_state = 0; md_timer = HOLD; md_persist = 0; md_sus = 0; md_iso = 3'b000;
      md_fc = '{0, 0, 0}; md_trans = 0; md_res = 0;
      return;
    end
    m = mis & ~md_iso;
    n = $countones(m);
    case (md_state)
      0: begin
        md_timer--;
        if (md_timer == 0) begin md_state = 4; md_timer = SETTLE; end
      end
      4: begin
        md_timer--;
        if (md_timer == 0) md_state = 1;
      end
      1: begin
        if (req) md_enter_hold(-1);
        else if (n >= 2) md_state = 5;
        else if (n == 1 && md_iso != 3'b000) md_state = 5;
        else if (n == 1) begin
          md_state = 2;
          md_persist = 1;
          for (int i = 2; i >= 0; i--) if (m[i]) md_sus = i;
        end
      end
      2: begin
        if (n > (m[md_sus] ? 1 : 0)) md_state = 5;
        else if (m[md_sus]) begin
          md_persist++;
          if (md_persist >= PERSIST) md_enter_hold(md_sus);
        end else begin
          md_state = 1;
          if (md_trans < 255) md_trans++;
        end
      end
      3: begin
        md_timer--;
        if (md_timer == 0) begin
          md_state = 4; md_timer = SETTLE;
          if (md_res < 255) md_res++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [39:0] exp_vec();
    bit       live;
    bit [2:0] rstn;
    live = !(md_state == 0 || md_state == 3 || md_state == 5);
    rstn = live ? ~md_iso : 3'b000;
    return {3'(md_state), rstn, md_iso, (md_iso != 3'b000), (md_state == 5), (md_state != 1),
            4'(md_fc[2]), 4'(md_fc[1]), 4'(md_fc[0]), 8'(md_trans), 8'(md_res)};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {state_o, rst_n_core_c, rst_n_core_b, rst_n_core_a, isolated, degraded, fatal, busy,
            fault_cnt_c, fault_cnt_b, fault_cnt_a, transient_cnt, resync_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, {mismatch_c, mismatch_b, mismatch_a}, resync_req);
    #1;
    chk("model", dut_vec(), exp_vec());
  endtask

  task automatic drive(input logic [2:0] mis, input logic req);
    {mismatch_c, mismatch_b, mismatch_a} = mis;
    resync_req = req;
  endtask

  task automatic wait_state(input string nm, input logic [2:0] target, input int budget);
    int n = 0;
    while (state_o !== target && n < budget) begin tick(); n++; end
    chk(nm, state_o, target);
  endtask

  function automatic logic [2:0] rstn_v();
    return {rst_n_core_c, rst_n_core_b, rst_n_core_a};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] mis;
    logic       req;
    logic [2:0] st;
    logic [2:0] rstn;
    logic [7:0] trans;
    logic [3:0] fcb;
    logic [7:0] res;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] mis, input logic req, input logic [2:0] st,
                              input logic [2:0] rstn, input logic [7:0] trans,
                              input logic [3:0] fcb, input logic [7:0] res);
    vec_t v;
    v.mis = mis; v.req = req; v.st = st; v.rstn = rstn; v.trans = trans; v.fcb = fcb; v.res = res;
    tbl.push_back(v);
  endfunction

  logic [2:0] cur;
  int         r;
  int         fatal_age;

  initial begin
    // transient on b: QUALIFY, QUALIFY, back to RUN with one transient
    add(3'b010, 1'b0, 3'd2, 3'b111, 8'd0, 4'd0, 8'd0);
    add(3'b010, 1'b0, 3'd2, 3'b111, 8'd0, 4'd0, 8'd0);
    add(3'b000, 1'b0, 3'd1, 3'b111, 8'd1, 4'd0, 8'd0);
    add(3'b000, 1'b0, 3'd1, 3'b111, 8'd1, 4'd0, 8'd0);
    // resync_req wins over mismatch_b: HOLD with no suspect
    add(3'b010, 1'b1, 3'd3, 3'b000, 8'd1, 4'd0, 8'd0);
    // inputs are ignored while holding and settling
    for (int i = 0; i < HOLD - 1; i++)
      add(3'(i), 1'(i % 2), 3'd3, 3'b000, 8'd1, 4'd0, 8'd0);
    add(3'b111, 1'b1, 3'd4, 3'b111, 8'd1, 4'd0, 8'd1);
    for (int i = 0; i < SETTLE - 1; i++)
      add(3'(i + 1), 1'(i % 2), 3'd4, 3'b111, 8'd1, 4'd0, 8'd1);
    add(3'b000, 1'b0, 3'd1, 3'b111, 8'd1, 4'd0, 8'd1);

    // ---- reset state ----
    drive(3'b000, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_state", state_o, 3'd0);
      chk("rst_rstn", rstn_v(), 3'b000);
      chk("rst_busy", busy, 1'b1);
      chk("rst_fatal_iso", {fatal, degraded, isolated}, 5'd0);
    end
    rst = 1'b0;

    // ---- power-up: 16 cycles of core reset, all release on one edge, 8 settle ----
    for (int i = 0; i < HOLD; i++) begin
      tick();
      chk("init_state", state_o, (i < HOLD - 1) ? 3'd0 : 3'd4);
      chk("init_rstn", rstn_v(), (i < HOLD - 1) ? 3'b000 : 3'b111);
    end
    for (int i = 0; i < SETTLE; i++) begin
      tick();
      chk("settle_state", state_o, (i < SETTLE - 1) ? 3'd4 : 3'd1);
      chk("settle_busy", busy, (i < SETTLE - 1) ? 1'b1 : 1'b0);
    end

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mis, tbl[i].req);
      tick();
      chk("tbl_state", state_o, tbl[i].st);
      chk("tbl_rstn", rstn_v(), tbl[i].rstn);
      chk("tbl_trans", transient_cnt, tbl[i].trans);
      chk("tbl_fcb", fault_cnt_b, tbl[i].fcb);
      chk("tbl_res", resync_count, tbl[i].res);
    end

    // ---- persistent fault on a: reset after 4th sampled edge, 16 cycles ----
    drive(3'b001, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("qa_state", state_o, (i < PERSIST) ? 3'd2 : 3'd3);
      chk("qa_rstn", rstn_v(), (i < PERSIST) ? 3'b111 : 3'b000);
    end
    drive(3'b000, 1'b0);
    for (int i = 7; i <= PERSIST + HOLD; i++) begin
      tick();
      chk("qa_hold", state_o, (i < PERSIST + HOLD) ? 3'd3 : 3'd4);
    end
    chk("qa_fca", fault_cnt_a, 4'd1);
    chk("qa_res", resync_count, 8'd2);
    wait_state("qa_run", 3'd1, 20);

    // ---- three qualified faults on c -> isolation ----
    for (int f = 1; f <= 3; f++) begin
      drive(3'b100, 1'b0);
      for (int i = 0; i < PERSIST; i++) tick();
      chk("qc_state", state_o, 3'd3);
      chk("qc_fcc", fault_cnt_c, 4'(f));
      chk("qc_iso", isolated, (f >= MAXR) ? 3'b100 : 3'b000);
      chk("qc_rstn", rstn_v(), 3'b000);
      drive(3'b000, 1'b0);
      wait_state("qc_run", 3'd1, 40);
    end
    chk("iso_degraded", degraded, 1'b1);
    chk("iso_rstn", rstn_v(), 3'b011);
    // the isolated core's flag no longer counts
    drive(3'b100, 1'b0);
    tick(); tick();
    chk("iso_ignore_c", state_o, 3'd1);
    // a single disagreement with only two voters left is fatal
    drive(3'b001, 1'b0);
    tick();
    chk("deg_fatal_state", state_o, 3'd5);
    chk("deg_fatal_flag", fatal, 1'b1);
    chk("deg_fatal_rstn", rstn_v(), 3'b000);
    drive(3'b011, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("fatal_sticky", state_o, 3'd5);

    // ---- reset from FATAL ----
    rst = 1'b1;
    tick();
    chk("midrst_state", state_o, 3'd0);
    chk("midrst_iso", {isolated, degraded, fatal}, 5'd0);
    chk("midrst_cnt", {fault_cnt_c, fault_cnt_a, resync_count, transient_cnt}, 24'd0);
    rst = 1'b0;
    drive(3'b000, 1'b0);
    wait_state("midrst_run", 3'd1, 40);

    // ---- double mismatch in RUN -> FATAL, held ----
    drive(3'b101, 1'b0);
    tick();
    chk("dbl_state", state_o, 3'd5);
    chk("dbl_fatal", fatal, 1'b1);
    chk("dbl_rstn", rstn_v(), 3'b000);
    drive(3'b000, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("dbl_held", {state_o, fatal}, {3'd5, 1'b1});

    // ---- randomized episodes against the model ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur = 3'b000;
    fatal_age = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 25) begin
        r = int'($urandom_range(0, 99));
        if (r < 60)      cur = 3'b000;
        else if (r < 92) cur = 3'(3'b001 << $urandom_range(0, 2));
        else             cur = 3'($urandom_range(0, 7));
      end
      drive(cur, ($urandom_range(0, 149) == 0));
      rst = ($urandom_range(0, 999) == 0) || (fatal_age > 30);
      tick();
      fatal_age = fatal ? fatal_age + 1 : 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tmr_resync_scheduler.md
TMR_RESYNC_SCHEDULER -- requirements
Module: tmr_resync_scheduler

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PERSIST_CYCLES, 4: consecutive mismatch samples needed to qualify a fault.
- HOLD_CYCLES, 16: core reset assertion length.
- SETTLE_CYCLES, 8: post-release mismatch blanking.
- MAX_RETRIES, 3: faults on one core before it is isolated.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst, in, 1: synchronous active-high reset.
- mismatch_a/b/c, in, 1 each: voter minority flag per core.
- resync_req, in, 1: software resync request pulse.
- rst_n_core_a/b/c, out, 1 each: active-low core resets.
- isolated, out, 3: isolated-core mask {c,b,a}.
- degraded, out, 1: any core isolated.
- fatal, out, 1: unrecoverable disagreement.
- busy, out, 1: state != RUN.
- state_o, out, 3: FSM state.
- fault_cnt_a/b/c, out, 4 each: qualified faults per core.
- transient_cnt, out, 8: unqualified mismatch episodes.
- resync_count, out, 8: completed resyncs.
REQ-003 There is one clock; reset is synchronous and active-high. Ports are clk and rst. All outputs are registered.

Function
REQ-004 FSM states and encoding: INIT=0, RUN=1, QUALIFY=2, HOLD=3, SETTLE=4, FATAL=5.
REQ-005 Effective mismatch vector m = {mismatch_c, mismatch_b, mismatch_a} & ~isolated.
REQ-006 rst_n_core_x = 0 when state is INIT, HOLD or FATAL, or when isolated[x] = 1; otherwise 1. It updates on the same edge as the state transition, so all non-isolated cores change on one edge.
REQ-007 INIT: hold for HOLD_CYCLES cycles, then go to SETTLE.
REQ-008 SETTLE: ignore m for SETTLE_CYCLES cycles, then go to RUN.
REQ-009 RUN transitions, first match wins:
- resync_req=1 -> HOLD with no suspect.
- popcount(m) >= 2 -> FATAL.
- degraded=1 and popcount(m) = 1 -> FATAL.
- popcount(m) = 1 -> QUALIFY. Latch the suspect index; persist counter = 1.
REQ-010 QUALIFY transitions:
- Any non-suspect bit of m set -> FATAL.
- Suspect bit still set -> increment the persist counter; on reaching PERSIST_CYCLES -> HOLD with the suspect.
- Suspect bit clear -> RUN, and transient_cnt increments, saturating at 0xFF.
- resync_req is ignored in QUALIFY.
REQ-011 On HOLD entry with a suspect, fault_cnt_<suspect> increments, saturating at 15. If the new value >= MAX_RETRIES, isolated[suspect] is set on the same edge.
REQ-012 HOLD lasts HOLD_CYCLES cycles, then goes to SETTLE. resync_count increments (saturating at 0xFF) on the HOLD->SETTLE edge.
REQ-013 FATAL is terminal until rst. It holds fatal=1, and every rst_n_core is 0.
REQ-014 degraded = |isolated. isolated bits clear only on rst.
REQ-015 resync_req and mismatch inputs are ignored in INIT, HOLD, SETTLE and FATAL.
REQ-016 Cycle counters are sized $clog2(max parameter + 1). Each restarts at 0 on every state entry.

Reset
REQ-017 While rst=1, the block takes these values on each clock edge:
- state = INIT; all rst_n_core_* = 0.
- isolated = 0; degraded = 0; fatal = 0; busy = 1.
- All counters = 0.
REQ-018 Reset applied mid-operation (any state) takes effect on the next edge, and behaviour restarts from INIT.

Verification
REQ-019 rst high 3 cycles, then low, no mismatches -> rst_n_core_a/b/c = 0 for 16 cycles, all rise on one edge. State is SETTLE for 8 cycles, then RUN with busy=0.
REQ-020 In RUN, mismatch_b high 2 cycles -> QUALIFY then RUN. No core reset; transient_cnt = 1; fault_cnt_b = 0.
REQ-021 In RUN, mismatch_a high 6 cycles:
- All three rst_n_core go low after the 4th sampled edge and stay low 16 cycles.
- fault_cnt_a = 1; resync_count = 1.
REQ-022 Three qualified faults on core c, each separated by RUN:
- After the third: isolated = 3'b100, degraded = 1, rst_n_core_c stays 0.
- rst_n_core_a/b are released after HOLD.
- A subsequent mismatch_a in RUN -> FATAL.
REQ-023 In RUN, mismatch_a and mismatch_c set on the same cycle -> FATAL next edge: fatal = 1, all rst_n_core = 0, state_o = 5, held until rst.
REQ-024 In RUN, resync_req and mismatch_b on the same cycle -> HOLD with no suspect. fault_cnt_b = 0; resync_count increments by 1.
